// File: rtl/matrix_stream_writer.sv
// matrix_stream_writer
// Latches one packed DIM x DIM matrix of signed DATA_W-bit elements and
// streams the active n x n window (n = size + 2) out row-major, one element
// per accepted beat, with its grid address and a last-beat marker. A one-cycle
// done pulse follows the final accepted beat.
//
// Handshake: a beat transfers on a rising clock edge when out_valid && out_ready.
// While out_valid is high and out_ready is low, out_data/out_addr/out_last
// hold steady and out_valid stays high. out_ready is a don't-care when
// out_valid is low.

module matrix_stream_writer #(
  parameter int DATA_W = 8,
  parameter int DIM    = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DIM*DIM*DATA_W-1:0] matrix,
  input  logic [1:0]                size,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [4:0]                out_addr,
  output logic                      out_last,
  output logic                      done,
  output logic [1:0]                dbg_state
);

  localparam int BUS_W  = DIM * DIM * DATA_W;
  localparam int CNT_W  = 3;
  localparam int ADDR_W = 5;
  localparam int NUM_EL = DIM * DIM;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Latched copies of the request; the live inputs are ignored once streaming.
  logic [BUS_W-1:0]  mat_q;
  logic [1:0]        size_q;

  // Position of the beat currently presented (or about to be presented).
  logic [CNT_W-1:0]  row;
  logic [CNT_W-1:0]  col;

  // Highest row/col index of the active window: n-1 = size+1.
  logic [CNT_W-1:0]  lim;

  logic              accept;
  logic              xfer;
  logic              at_row_end;
  logic              at_last_row;
  logic              at_last;
  logic [ADDR_W-1:0] grid_addr;

  // Unpacked view of the latched bus; element k = 5*i+j sits at the top end
  // of the bus for k = 0 and at the bottom for k = 24.
  logic [DATA_W-1:0] elem [NUM_EL];

  for (genvar k = 0; k < NUM_EL; k++) begin : g_unpack
    assign elem[k] = mat_q[BUS_W-1-DATA_W*k -: DATA_W];
  end

  assign lim         = {{(CNT_W-2){1'b0}}, size_q} + CNT_W'(1);
  assign accept      = (state == S_IDLE) && start;
  assign xfer        = (state == S_SEND) && out_ready;
  assign at_row_end  = (col == lim);
  assign at_last_row = (row == lim);
  assign at_last     = at_row_end && at_last_row;
  assign grid_addr   = ADDR_W'(row) * ADDR_W'(DIM) + ADDR_W'(col);

  // State register: reset drops straight to IDLE, abandoning any beat in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: IDLE -> SEND on start, SEND -> DONE on the last accepted
  // beat, DONE always returns to IDLE so a start seen during DONE is dropped.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_SEND;
        end
      end
      S_SEND: begin
        if (xfer && at_last) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Output logic: everything is a function of state and the latched data, so
  // the presented beat cannot change while the sink stalls.
  always_comb begin
    busy      = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_addr  = '0;
    out_last  = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = elem[grid_addr];
        out_addr  = grid_addr;
        out_last  = at_last;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign dbg_state = state;

  // Request latch: captured only when a start is accepted in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mat_q  <= '0;
      size_q <= '0;
    end else if (accept) begin
      mat_q  <= matrix;
      size_q <= size;
    end
  end

  // Row/column walk over the active window; advances only on a transfer and
  // wraps to the next row after column n-1, so no index ever exceeds n-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      row <= '0;
      col <= '0;
    end else if (xfer) begin
      if (at_row_end) begin
        col <= '0;
        if (at_last_row) begin
          row <= '0;
        end else begin
          row <= row + CNT_W'(1);
        end
      end else begin
        col <= col + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_matrix_stream_writer.sv
// Directed bench for matrix_stream_writer: reset/idle, full 5x5 stream,
// 2x2 window, backpressure with a -128 element, ignored inputs during SEND
// and DONE, and mid-stream abort followed by restart.

module tb_matrix_stream_writer;

  localparam int DATA_W = 8;
  localparam int DIM    = 5;
  localparam int BUS_W  = DIM * DIM * DATA_W;

  // ---------------- clock / reset / DUT ----------------
  logic             clk       = 1'b0;
  logic             rst       = 1'b0;
  logic             start     = 1'b0;
  logic [BUS_W-1:0] matrix    = '0;
  logic [1:0]       size      = 2'd0;
  logic             out_ready = 1'b0;

  logic             busy;
  logic             out_valid;
  logic [7:0]       out_data;
  logic [4:0]       out_addr;
  logic             out_last;
  logic             done;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  matrix_stream_writer #(.DATA_W(DATA_W), .DIM(DIM)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .matrix    (matrix),
    .size      (size),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_last  (out_last),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  // Entry layout: {last, addr[4:0], data[7:0]}
  logic [13:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Element (i,j) = 5*i+j-12, so index k carries k-12 (-12..12).
  function automatic logic [BUS_W-1:0] ramp_matrix();
    logic [BUS_W-1:0] m;
    m = '0;
    for (int k = 0; k < DIM * DIM; k++) begin
      m[BUS_W-1-8*k -: 8] = 8'(k - 12);
    end
    return m;
  endfunction

  task automatic push_beat(input int addr, input logic [7:0] data, input logic last);
    exp_q.push_back({last, 5'(addr), data});
  endtask

  task automatic push_ramp_window(input int n);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        push_beat(5 * i + j, 8'(5 * i + j - 12), (i == n - 1) && (j == n - 1));
      end
    end
  endtask

  task automatic push_2x2_table();
    push_beat(0, 8'hF4, 1'b0);  // -12
    push_beat(1, 8'hF5, 1'b0);  // -11
    push_beat(5, 8'hF9, 1'b0);  // -7
    push_beat(6, 8'hFA, 1'b1);  // -6
  endtask

  // ---------------- driver / monitor ----------------
  // Called with start already driven high; the first negedge is the first
  // cycle after acceptance. Returns on the negedge showing done, after
  // stop_after accepted beats (if non-zero), or when the budget expires.
  task automatic run_stream(input int budget, input int ready_mode, input int disturb,
                            input int stop_after,
                            output int beats, output int busy_cycles, output int done_cycle);
    logic [13:0] prev;
    logic [13:0] got;
    logic [13:0] want;
    logic        prev_stall;
    logic        rdy;
    beats       = 0;
    busy_cycles = 0;
    done_cycle  = -1;
    prev_stall  = 1'b0;
    prev        = '0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      got = {out_last, out_addr, out_data};
      if (c == 0) check("first_beat_valid", 32'(out_valid), 32'd1);
      if (prev_stall) begin
        check("stall_valid_held", 32'(out_valid), 32'd1);
        check("stall_beat_held", 32'(got), 32'(prev));
      end
      if (done) begin
        done_cycle = c;
        check("done_cycle_busy_valid", 32'({busy, out_valid}), 32'd0);
        break;
      end
      if (busy) busy_cycles++;
      rdy = (ready_mode != 0) ? (c % 3 == 0) : 1'b1;
      if (disturb != 0 && c == 3) begin
        start  = 1'b1;
        matrix = {25{8'h55}};
        size   = 2'd3;
      end else begin
        start = 1'b0;
      end
      out_ready  = rdy;
      prev       = got;
      prev_stall = out_valid && !rdy;
      if (out_valid && rdy) begin
        if (exp_q.size() == 0) begin
          check("beat_expected", 32'(got), 32'hFFFF_FFFF);
        end else begin
          want = exp_q.pop_front();
          check("beat_addr", 32'(out_addr), 32'(want[12:8]));
          check("beat_data", 32'(out_data), 32'(want[7:0]));
          check("beat_last", 32'(out_last), 32'(want[13]));
        end
        beats++;
        if (stop_after != 0 && beats == stop_after) break;
      end
    end
    start = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int beats;
    int busy_cycles;
    int done_cycle;
    logic [BUS_W-1:0] m;

    // Reset / idle
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({busy, out_valid, out_data, out_addr, out_last, done}), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_valid_low", 32'(out_valid), 32'd0);
    end
    check("idle_busy_done", 32'({busy, done}), 32'd0);

    // Full 5x5 stream, always ready
    matrix = ramp_matrix();
    size   = 2'd3;
    push_ramp_window(5);
    start  = 1'b1;
    run_stream(60, 0, 0, 0, beats, busy_cycles, done_cycle);
    check("full_beats", 32'(beats), 32'd25);
    check("full_busy_cycles", 32'(busy_cycles), 32'd25);
    check("full_done_cycle", 32'(done_cycle), 32'd25);
    check("full_queue_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'({done, out_valid, busy}), 32'd0);

    // 2x2 window of the same matrix
    size  = 2'd0;
    push_2x2_table();
    start = 1'b1;
    run_stream(20, 0, 0, 0, beats, busy_cycles, done_cycle);
    check("win2_beats", 32'(beats), 32'd4);
    check("win2_done_cycle", 32'(done_cycle), 32'd4);
    check("win2_queue_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);

    // Backpressure 3x3 with -128 at (1,1)
    m = ramp_matrix();
    m[BUS_W-1-8*6 -: 8] = 8'h80;
    matrix = m;
    size   = 2'd1;
    push_beat(0,  8'hF4, 1'b0);
    push_beat(1,  8'hF5, 1'b0);
    push_beat(2,  8'hF6, 1'b0);
    push_beat(5,  8'hF9, 1'b0);
    push_beat(6,  8'h80, 1'b0);
    push_beat(7,  8'hFB, 1'b0);
    push_beat(10, 8'hFE, 1'b0);
    push_beat(11, 8'hFF, 1'b0);
    push_beat(12, 8'h00, 1'b1);
    start = 1'b1;
    run_stream(100, 1, 0, 0, beats, busy_cycles, done_cycle);
    check("bp_beats", 32'(beats), 32'd9);
    check("bp_done_seen", 32'(done_cycle > 0), 32'd1);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Ignored inputs during SEND, then start during DONE
    @(negedge clk);
    matrix = ramp_matrix();
    size   = 2'd1;
    push_ramp_window(3);
    start  = 1'b1;
    run_stream(40, 0, 1, 0, beats, busy_cycles, done_cycle);
    check("ign_beats", 32'(beats), 32'd9);
    check("ign_done_cycle", 32'(done_cycle), 32'd9);
    check("ign_queue_empty", 32'(exp_q.size()), 32'd0);
    // Still on the done negedge: this start must be ignored
    matrix = ramp_matrix();
    size   = 2'd0;
    start  = 1'b1;
    @(negedge clk);
    check("start_in_done_ignored", 32'({busy, out_valid}), 32'd0);
    check("start_in_done_state", 32'(dbg_state), 32'd0);
    push_2x2_table();
    run_stream(20, 0, 0, 0, beats, busy_cycles, done_cycle);
    check("restart_beats", 32'(beats), 32'd4);
    check("restart_done_cycle", 32'(done_cycle), 32'd4);
    @(negedge clk);

    // Abort after 7 accepted beats
    matrix = ramp_matrix();
    size   = 2'd3;
    push_ramp_window(5);
    start  = 1'b1;
    run_stream(60, 0, 0, 7, beats, busy_cycles, done_cycle);
    check("abort_beats", 32'(beats), 32'd7);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_outputs", 32'({out_valid, busy, done}), 32'd0);
    check("abort_state", 32'(dbg_state), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    size = 2'd0;
    push_2x2_table();
    start = 1'b1;
    run_stream(20, 0, 0, 0, beats, busy_cycles, done_cycle);
    check("post_abort_beats", 32'(beats), 32'd4);
    check("post_abort_done_cycle", 32'(done_cycle), 32'd4);
    check("post_abort_queue_empty", 32'(exp_q.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
